// File: rtl/calc_display_if.sv
// Bus between the calc result source and the 7-segment display driver.
// Bundles the result word, load strobe, format select and the display outputs.
interface calc_display_if;
    logic [15:0] value;
    logic        load;
    logic        dec_mode;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        busy;

    modport master (
        output value, load, dec_mode,
        input  an, seg, dp, busy
    );

    modport slave (
        input  value, load, dec_mode,
        output an, seg, dp, busy
    );
endinterface

// File: rtl/calc_display.sv
// Shows a 16-bit result on a 4-digit multiplexed 7-segment display, as hex or as
// signed decimal converted by a sequential double-dabble engine.
module calc_display #(
    parameter int unsigned REFRESH_DIV = 16
) (
    input logic           clk,
    input logic           rst_n,
    calc_display_if.slave bus
);
    localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [4:0] CodeBlank = 5'h10;
    localparam logic [4:0] CodeMinus = 5'h11;

    typedef enum logic [1:0] {StIdle, StConv, StCommit} state_t;

    state_t          state_q, state_d;
    logic [15:0]     mag_q, mag_d;
    logic [19:0]     bcd_q, bcd_d;
    logic [3:0]      iter_q, iter_d;
    logic            sign_q, sign_d;
    logic [3:0][4:0] dbuf_q, dbuf_d;
    logic [3:0][4:0] fmt;
    logic [19:0]     adj;
    logic [CW-1:0]   cnt_q;
    logic [1:0]      idx_q;
    logic [3:0]      an_q;
    logic [6:0]      seg_q;

    function automatic logic [6:0] seg_of(input logic [4:0] code);
        logic [6:0] s;
        case (code)
            5'h00:   s = 7'b1000000;
            5'h01:   s = 7'b1111001;
            5'h02:   s = 7'b0100100;
            5'h03:   s = 7'b0110000;
            5'h04:   s = 7'b0011001;
            5'h05:   s = 7'b0010010;
            5'h06:   s = 7'b0000010;
            5'h07:   s = 7'b1111000;
            5'h08:   s = 7'b0000000;
            5'h09:   s = 7'b0010000;
            5'h0A:   s = 7'b0001000;
            5'h0B:   s = 7'b0000011;
            5'h0C:   s = 7'b1000110;
            5'h0D:   s = 7'b0100001;
            5'h0E:   s = 7'b0000110;
            5'h0F:   s = 7'b0001110;
            5'h11:   s = 7'b0111111;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Scanning free-runs; an/seg are registered so they trail idx_q by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            idx_q <= 2'd0;
            an_q  <= 4'b1110;
            seg_q <= 7'b1000000;
        end else begin
            if (cnt_q == CW'(REFRESH_DIV - 1)) begin
                cnt_q <= '0;
                idx_q <= idx_q + 2'd1;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
            an_q  <= ~(4'b0001 << idx_q);
            seg_q <= seg_of(dbuf_q[idx_q]);
        end
    end

    // Double-dabble correction of every BCD nibble before the shift.
    always_comb begin
        adj = bcd_q;
        for (int k = 0; k < 5; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
        end
    end

    // Decimal formatting of the finished BCD value.
    always_comb begin
        int msd;
        fmt = '0;
        msd = 0;
        for (int k = 1; k < 4; k++) begin
            if (bcd_q[4*k +: 4] != 4'd0) msd = k;
        end
        if (bcd_q[19:16] != 4'd0 || (sign_q && bcd_q[15:12] != 4'd0)) begin
            fmt = {4{CodeMinus}};
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (k > msd) fmt[k] = CodeBlank;
                else         fmt[k] = {1'b0, bcd_q[4*k +: 4]};
                if (sign_q && k == msd + 1) fmt[k] = CodeMinus;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        mag_d   = mag_q;
        bcd_d   = bcd_q;
        iter_d  = iter_q;
        sign_d  = sign_q;
        dbuf_d  = dbuf_q;
        if (bus.load) begin
            // A load always wins, aborting any conversion in flight.
            if (bus.dec_mode) begin
                sign_d  = bus.value[15];
                mag_d   = bus.value[15] ? (~bus.value + 16'd1) : bus.value;
                bcd_d   = '0;
                iter_d  = '0;
                state_d = StConv;
            end else begin
                dbuf_d  = {{1'b0, bus.value[15:12]}, {1'b0, bus.value[11:8]},
                           {1'b0, bus.value[7:4]},   {1'b0, bus.value[3:0]}};
                state_d = StIdle;
            end
        end else begin
            case (state_q)
                StIdle: ;
                StConv: begin
                    {bcd_d, mag_d} = {adj[18:0], mag_q, 1'b0};
                    iter_d         = iter_q + 4'd1;
                    if (iter_q == 4'd15) state_d = StCommit;
                end
                StCommit: begin
                    dbuf_d  = fmt;
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            mag_q   <= '0;
            bcd_q   <= '0;
            iter_q  <= '0;
            sign_q  <= 1'b0;
            dbuf_q  <= '0;
        end else begin
            state_q <= state_d;
            mag_q   <= mag_d;
            bcd_q   <= bcd_d;
            iter_q  <= iter_d;
            sign_q  <= sign_d;
            dbuf_q  <= dbuf_d;
        end
    end

    assign bus.an   = an_q;
    assign bus.seg  = seg_q;
    assign bus.dp   = 1'b1;
    assign bus.busy = (state_q != StIdle);
endmodule

// File: doc/calc_display.md
Name: calc_display

Overview:
- Output-side companion to `calc`. It reads the 16-bit accumulator result that `calc` drives on `led` and shows it on the board's 4-digit multiplexed 7-segment display.
- Two formats: hex, or signed decimal. Decimal values are produced by a sequential double-dabble (binary-to-BCD) converter.
- Scanning of the digits runs continuously and independently of conversion.

Parameters:
- REFRESH_DIV, 16: clock cycles each digit stays lit. Must be ≥ 2.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- value  in  16  result word, normally `calc.led`
- load  in  1  1-cycle strobe; captures `value` and `dec_mode`
- dec_mode  in  1  1 = signed decimal, 0 = hex
- an  out  4  active-low digit enables; an[0] is the rightmost digit
- seg  out  7  active-low segments, ordered {g,f,e,d,c,b,a}
- dp  out  1  active-low decimal point; held at 1
- busy  out  1  decimal conversion in progress

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE; busy=0; scan index=0; refresh counter=0.
  - Display buffer = four hex '0' codes.
  - an=4'b1110, seg=7'b1000000, dp=1.
- Display buffer:
  - 4 entries of 5 bits each.
  - Codes 0x00–0x0F are hex/BCD digits; 0x10 = BLANK (7'b1111111); 0x11 = MINUS (7'b0111111).
- Segment map (active-low):
  - 0:1000000, 1:1111001, 2:0100100, 3:0110000
  - 4:0011001, 5:0010010, 6:0000010, 7:1111000
  - 8:0000000, 9:0010000, A:0001000, b:0000011
  - C:1000110, d:0100001, E:0000110, F:0001110
- Scan:
  - Refresh counter counts 0..REFRESH_DIV-1 and wraps.
  - Scan index advances on each wrap: 0→1→2→3→0.
  - an and seg are registered from scan index and buffer, so they trail the index by 1 cycle.
  - an is always exactly one-hot low.
- FSM states: IDLE, CONV, COMMIT.
- IDLE, load=1, dec_mode=0:
  - On the next edge, the buffer gets value[3:0] in digit 0, up to value[15:12] in digit 3.
  - busy stays 0; the FSM stays in IDLE.
- IDLE, load=1, dec_mode=1:
  - Capture sign = value[15] and mag = |value| as a 16-bit unsigned number (0x8000 → 32768).
  - Clear the 20-bit BCD register and the iteration counter; go to CONV; set busy=1.
- CONV:
  - One double-dabble step per cycle: add 3 to each BCD nibble ≥ 5, then shift {bcd, mag} left by 1.
  - After exactly 16 steps, go to COMMIT.
- COMMIT (1 cycle): write the buffer, go to IDLE, clear busy.
  - busy is high for 17 cycles total; load-to-buffer-update latency is 17 edges.
- Decimal formatting at COMMIT:
  - Overflow if BCD > 9999, or if sign=1 and BCD > 999. Overflow writes MINUS to all 4 digits.
  - Otherwise blank leading zeros; digit 0 is never blanked.
  - If sign=1, place MINUS immediately left of the most significant shown digit.
- Load during CONV or COMMIT: restarts capture with the new value and mode. No buffer write occurs for the aborted conversion.
- The buffer keeps its previous contents until COMMIT, so the display never shows partial results.
- A change on dec_mode without load has no effect.
- Reset mid-conversion: immediate return to the reset state; the partial result is discarded.

Test Plan:
- Reset, then wait 4·REFRESH_DIV cycles:
  - an steps 1110→1101→1011→0111→1110, once per REFRESH_DIV cycles.
  - seg=1000000 on every digit; busy=0.
- value=16'h1234, dec_mode=0, load 1 cycle:
  - Buffer updates on the next edge; busy never rises.
  - an=1110 shows 0011001 ('4'); an=0111 shows 1111001 ('1').
- value=16'hFFFF, dec_mode=1, load:
  - busy=1 for 17 cycles.
  - Then digits 3..0 = BLANK, BLANK, MINUS, '1'; seg on an=1101 is 0111111.
- Decimal boundaries:
  - 16'h270F → "9999".
  - 16'h2710 → "----".
  - 16'hFC19 → "-999".
  - 16'hFC18 → "----".
  - 16'h8000 → "----".
  - 16'h0000 → blank, blank, blank, '0'.
- Load 16'h0064 decimal, then at busy cycle 5 load 16'h00FF decimal:
  - busy stays high until 17 cycles after the second load.
  - Display shows "255"; "100" never appears.
- Load 16'h0064 decimal, then assert rst_n=0 at busy cycle 8:
  - busy=0, an=1110, seg=1000000 immediately.
  - After release, the display shows "0000" and no commit occurs.
